// File: rtl/burrito_secuenciador.sv
// Instruction sequencer/decoder for the Burrito datapath: fetches 18-bit words
// from a synchronous ROM starting at address 0 and issues one write per instruction.
module burrito_secuenciador #(
  parameter int PC_W   = 6,
  parameter int ADDR_W = 5,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [17:0]       instr_in,
  output logic              mem_rd,
  output logic [PC_W-1:0]   pc_out,
  output logic [ADDR_W-1:0] Dir1,
  output logic [ADDR_W-1:0] Dir2,
  output logic [ADDR_W-1:0] DirEs,
  output logic [SEL_W-1:0]  Selec,
  output logic              we,
  output logic              busy,
  output logic              done,
  output logic [PC_W:0]     instr_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_next;
  logic [17:0]     r_ir;
  logic [17:0]     w_ir_next;
  logic [PC_W:0]   r_count;
  logic [PC_W:0]   w_count_next;
  logic            w_last_addr;
  logic            w_dest_zero;

  assign w_last_addr = (r_pc == {PC_W{1'b1}});
  assign w_dest_zero = (r_ir[7:3] == 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_count <= w_count_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ir_next    = r_ir;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_FETCH;
          w_pc_next    = '0;
          w_count_next = '0;
        end
      end
      S_FETCH: w_state_next = S_DECODE;
      S_DECODE: begin
        // A HALT word leaves IR untouched so the Dir/Selec outputs keep the last real instruction.
        if (instr_in == 18'd0) begin
          w_state_next = S_DONE;
        end else begin
          w_state_next = S_EXEC;
          w_ir_next    = instr_in;
        end
      end
      S_EXEC: begin
        w_count_next = r_count + (PC_W+1)'(1);
        if (w_last_addr) begin
          w_state_next = S_DONE;
        end else begin
          w_pc_next    = r_pc + PC_W'(1);
          w_state_next = S_FETCH;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from registers, so the async reset clears them without a clock.
  assign mem_rd      = (r_state == S_FETCH);
  assign we          = (r_state == S_EXEC) && !w_dest_zero;
  assign busy        = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign done        = (r_state == S_DONE);
  assign pc_out      = r_pc;
  assign instr_count = r_count;
  assign Dir1        = ADDR_W'(r_ir[17:13]);
  assign Dir2        = ADDR_W'(r_ir[12:8]);
  assign DirEs       = ADDR_W'(r_ir[7:3]);
  assign Selec       = SEL_W'(r_ir[2:0]);

endmodule

// File: tb/tb_burrito_secuenciador.sv
// Self-checking bench for burrito_secuenciador (PC_W=3): program-walk reference
// model compared every cycle, plus literal checks of the directed scenarios.
module tb_burrito_secuenciador;

  localparam int PW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [17:0] instr_in = 18'd0;
  logic        mem_rd;
  logic [PW-1:0] pc_out;
  logic [4:0]  Dir1, Dir2, DirEs;
  logic [3:0]  Selec;
  logic        we, busy, done;
  logic [PW:0] instr_count;

  burrito_secuenciador #(.PC_W(PW), .ADDR_W(5), .SEL_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .instr_in(instr_in),
    .mem_rd(mem_rd), .pc_out(pc_out), .Dir1(Dir1), .Dir2(Dir2), .DirEs(DirEs),
    .Selec(Selec), .we(we), .busy(busy), .done(done), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [17:0] rom [8];
  always @(posedge clk) if (mem_rd) instr_in <= rom[pc_out];

  typedef struct packed {
    logic       mem_rd;
    logic [2:0] pc;
    logic       we;
    logic       busy;
    logic       done;
    logic [4:0] d1;
    logic [4:0] d2;
    logic [4:0] de;
    logic [3:0] sel;
    logic [3:0] cnt;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [2:0] pc;
    logic [4:0] d1;
    logic [4:0] d2;
    logic [4:0] de;
    logic [3:0] sel;
  } ev_t;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   chk_en = 1'b0;
  ev_t  we_q[$];
  ev_t  fetch_q[$];
  int   done_q[$];
  int   busy_n = 0;

  // Reference model: walks the program and lists the expected outputs cycle by cycle.
  exp_t m_q[$];
  exp_t m_cur;
  bit   m_idle = 1'b1;
  logic [2:0] h_pc = '0;
  logic [3:0] h_cnt = '0;
  logic [4:0] h_d1 = '0, h_d2 = '0, h_de = '0;
  logic [3:0] h_sel = '0;

  function automatic exp_t idle_vec();
    exp_t v;
    v = '0;
    v.pc = h_pc; v.cnt = h_cnt;
    v.d1 = h_d1; v.d2 = h_d2; v.de = h_de; v.sel = h_sel;
    return v;
  endfunction

  task automatic build_run();
    exp_t v;
    logic [17:0] w;
    int cnt = 0;
    bit halted = 1'b0;
    for (int p = 0; p < 8 && !halted; p++) begin
      v = '0;
      v.pc = p[2:0]; v.cnt = cnt[3:0];
      v.d1 = h_d1; v.d2 = h_d2; v.de = h_de; v.sel = h_sel;
      v.busy = 1'b1; v.mem_rd = 1'b1;
      m_q.push_back(v);
      v.mem_rd = 1'b0;
      m_q.push_back(v);
      w = rom[p];
      if (w == 18'd0) begin
        v.busy = 1'b0; v.done = 1'b1;
        m_q.push_back(v);
        h_pc = p[2:0]; h_cnt = cnt[3:0];
        halted = 1'b1;
      end else begin
        h_d1 = w[17:13]; h_d2 = w[12:8]; h_de = w[7:3]; h_sel = {1'b0, w[2:0]};
        v.d1 = h_d1; v.d2 = h_d2; v.de = h_de; v.sel = h_sel;
        v.we = (w[7:3] != 5'd0);
        m_q.push_back(v);
        cnt++;
      end
    end
    if (!halted) begin
      v = idle_vec();
      v.pc = 3'd7; v.cnt = 4'd8; v.done = 1'b1;
      m_q.push_back(v);
      h_pc = 3'd7; h_cnt = 4'd8;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q.delete();
      h_pc = '0; h_cnt = '0; h_d1 = '0; h_d2 = '0; h_de = '0; h_sel = '0;
      m_cur = idle_vec();
      m_idle = 1'b1;
    end else begin
      if (m_idle && start) build_run();
      if (m_q.size() > 0) begin
        m_cur = m_q.pop_front();
        m_idle = 1'b0;
      end else begin
        m_cur = idle_vec();
        m_idle = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_log();
    we_q.delete(); fetch_q.delete(); done_q.delete(); busy_n = 0;
  endtask

  task automatic kick();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    for (int i = 0; i < budget && done_q.size() == 0; i++) begin
      @(negedge clk); #1;
    end
    check({name, "_timeout"}, done_q.size() > 0, 1);
    repeat (4) @(posedge clk);
    #2;
  endtask

  task automatic load_prog1();
    for (int i = 0; i < 8; i++) rom[i] = 18'd0;
    rom[0] = 18'b00001_00010_00011_000;
    rom[1] = 18'b00011_00100_00101_010;
    rom[2] = 18'b00001_00010_00110_101;
  endtask

  task automatic check_prog1(input string tag);
    check({tag, "_we_count"}, we_q.size(), 3);
    check({tag, "_done_count"}, done_q.size(), 1);
    check({tag, "_instr_count"}, instr_count, 3);
    if (we_q.size() >= 3 && fetch_q.size() >= 1) begin
      check({tag, "_we0_latency"}, we_q[0].cyc - fetch_q[0].cyc, 2);
      check({tag, "_we0_dirs"}, {we_q[0].d1, we_q[0].d2, we_q[0].de, we_q[0].sel}, {5'd1, 5'd2, 5'd3, 4'b0000});
      check({tag, "_we1_dirs"}, {we_q[1].d1, we_q[1].d2, we_q[1].de, we_q[1].sel}, {5'd3, 5'd4, 5'd5, 4'b0010});
      check({tag, "_we2_dirs"}, {we_q[2].d1, we_q[2].d2, we_q[2].de, we_q[2].sel}, {5'd1, 5'd2, 5'd6, 4'b0101});
      check({tag, "_we_gap01"}, we_q[1].cyc - we_q[0].cyc, 3);
      check({tag, "_we_gap12"}, we_q[2].cyc - we_q[1].cyc, 3);
    end
  endtask

  initial begin
    int k;
    int nwe;
    int h;
    logic [17:0] w;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst) begin
          if (we) we_q.push_back('{cyc, pc_out, Dir1, Dir2, DirEs, Selec});
          if (mem_rd) fetch_q.push_back('{cyc, pc_out, Dir1, Dir2, DirEs, Selec});
          if (done) done_q.push_back(cyc);
          if (busy) busy_n++;
          if (chk_en) begin
            check("cyc_mem_rd", mem_rd, m_cur.mem_rd);
            check("cyc_pc_out", pc_out, m_cur.pc);
            check("cyc_we", we, m_cur.we);
            check("cyc_busy", busy, m_cur.busy);
            check("cyc_done", done, m_cur.done);
            check("cyc_dirs", {Dir1, Dir2, DirEs, Selec}, {m_cur.d1, m_cur.d2, m_cur.de, m_cur.sel});
            check("cyc_instr_count", instr_count, m_cur.cnt);
          end
        end
      end
    join_none

    for (int i = 0; i < 8; i++) rom[i] = 18'd0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset_outputs", {mem_rd, we, busy, done}, 4'b0000);
    check("reset_dirs", {Dir1, Dir2, DirEs, Selec}, 19'd0);
    check("reset_pc_count", {pc_out, instr_count}, 7'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Three-instruction program ending in HALT
    load_prog1();
    clear_log(); kick(); wait_done(60, "prog1");
    check_prog1("prog1");

    // Immediate HALT
    for (int i = 0; i < 8; i++) rom[i] = 18'd0;
    clear_log(); kick(); wait_done(30, "halt0");
    check("halt0_we_count", we_q.size(), 0);
    check("halt0_count", instr_count, 0);
    check("halt0_busy_cycles", busy_n, 2);
    if (done_q.size() > 0 && fetch_q.size() > 0)
      check("halt0_done_latency", done_q[0] - fetch_q[0].cyc, 2);

    // Write to R0 is suppressed but counted
    rom[0] = 18'b00001_00010_00000_000;
    rom[1] = 18'd0;
    clear_log(); kick(); wait_done(30, "r0");
    check("r0_we_count", we_q.size(), 0);
    check("r0_count", instr_count, 1);
    check("r0_busy_cycles", busy_n, 5);
    check("r0_decoded", {Dir1, Dir2, DirEs}, {5'd1, 5'd2, 5'd0});

    // Full ROM with no HALT stops at the last address
    nwe = 0;
    for (int i = 0; i < 8; i++) begin
      w = 18'($urandom);
      if (w == 18'd0) w = 18'h2A5A9;
      rom[i] = w;
      if (w[7:3] != 5'd0) nwe++;
    end
    clear_log(); kick(); wait_done(60, "full");
    check("full_count", instr_count, 8);
    check("full_pc_out", pc_out, 7);
    check("full_fetches", fetch_q.size(), 8);
    check("full_we_count", we_q.size(), nwe);
    for (int i = 0; i < fetch_q.size(); i++) check("full_fetch_addr", fetch_q[i].pc, i);

    // Reset during the EXEC cycle of ROM[1]
    load_prog1();
    clear_log();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("rstx_we_before", we, 1);
    rst = 1'b1;
    #1;
    check("rstx_we_after", we, 0);
    check("rstx_busy_after", busy, 0);
    check("rstx_dirs_after", {Dir1, Dir2, DirEs, Selec}, 19'd0);
    check("rstx_count_after", instr_count, 0);
    @(posedge clk); #2 rst = 1'b0;
    clear_log(); kick(); wait_done(60, "rstx_rerun");
    check_prog1("rstx_rerun");

    // start pulsed during DECODE of ROM[1] is ignored
    clear_log();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (4) @(posedge clk);
    #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(60, "midstart");
    check_prog1("midstart");

    // start held through DONE restarts one cycle after IDLE
    for (int i = 0; i < 8; i++) rom[i] = 18'd0;
    clear_log();
    @(posedge clk); #2 start = 1'b1;
    repeat (12) @(posedge clk);
    #2 start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("hold_restarted", fetch_q.size() >= 2, 1);
    if (fetch_q.size() >= 2 && done_q.size() >= 1)
      check("hold_restart_gap", fetch_q[1].cyc - done_q[0], 2);

    // Randomized programs and start timing
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 8; i++) begin
        w = 18'($urandom);
        if ($urandom_range(0, 3) == 0) w[7:3] = 5'd0;
        if (w == 18'd0) w = 18'd1;
        rom[i] = w;
      end
      h = $urandom_range(0, 9);
      if (h < 8) rom[h] = 18'd0;
      k = $urandom_range(1, 30);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #2 start = 1'b1;
      repeat (k) @(posedge clk);
      #2 start = 1'b0;
      repeat (60) @(posedge clk);
      #2;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/burrito_secuenciador.md
Name: burrito_secuenciador

Overview:
- Instruction sequencer and decoder driving the Burrito datapath (register file + ALU).
- Fetches 18-bit instruction words from a synchronous instruction ROM and splits each into Dir1/Dir2/DirEs/Selec.
- Issues one register-file write strobe per instruction.
- Replaces hand-fed instruction vectors with autonomous program execution from address 0 until HALT.

Parameters:
- PC_W, 6, program counter width; ROM depth is 2**PC_W words.
- ADDR_W, 5, register address width (32 registers).
- SEL_W, 4, ALU select width; MSB is always 0.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin program execution at PC=0; sampled only in IDLE.
- instr_in  input  18  ROM read data; valid the cycle after mem_rd is asserted.
- mem_rd  output  1  ROM read enable.
- pc_out  output  PC_W  ROM read address.
- Dir1  output  ADDR_W  source register 1 = IR[17:13].
- Dir2  output  ADDR_W  source register 2 = IR[12:8].
- DirEs  output  ADDR_W  destination register = IR[7:3].
- Selec  output  SEL_W  ALU operation = {1'b0, IR[2:0]}.
- we  output  1  register-file write strobe; one cycle per executed instruction.
- busy  output  1  high from leaving IDLE until DONE.
- done  output  1  one-cycle pulse when the program ends.
- instr_count  output  PC_W+1  number of instructions executed in the current run.

Behaviour:
- Reset (async, any state): state=IDLE, PC=0, IR=0, instr_count=0. Outputs go low immediately, without waiting for a clock edge: mem_rd, we, busy, done, Dir1, Dir2, DirEs, Selec.
- Instruction format: [17:13] Dir1 | [12:8] Dir2 | [7:3] DirEs | [2:0] op. Word 18'b0 is HALT.
- State IDLE: busy=0. start=1 -> FETCH, PC=0, instr_count=0. Otherwise stay.
- State FETCH: mem_rd=1, pc_out=PC. Next state DECODE.
- State DECODE: IR <= instr_in.
  - instr_in==0 (HALT) -> DONE; IR is not updated and no write occurs.
  - Otherwise -> EXEC.
- State EXEC:
  - Dir1/Dir2/DirEs/Selec driven from IR.
  - we=1 unless DirEs==0 (R0 is read-only; the instruction still counts).
  - instr_count increments.
  - PC==2**PC_W-1 -> DONE (no wrap-around). Otherwise PC++ and -> FETCH.
- State DONE: done=1 for exactly one cycle, busy=0. Next state IDLE. PC and instr_count hold for inspection.
- Throughput: 3 cycles per instruction (FETCH, DECODE, EXEC). we asserts on cycles 3, 6, 9, ... after leaving IDLE.
- Output registration:
  - Dir/Selec outputs are registered from IR.
  - They hold their last decoded values outside EXEC.
  - Only we qualifies them.
- start while busy: ignored; no restart.
- start held high through DONE: a new run begins one cycle after returning to IDLE.
- Reset asserted during EXEC: we drops in the same cycle; no partial write is reported.
- Selec MSB is constant 0; op values 110 and 111 pass through unchanged (no decode error).
- mem_rd is high only in FETCH; pc_out is stable from FETCH through DECODE.

Test Plan:
- ROM[0]=18'b00001_00010_00011_000, ROM[1]=18'b00011_00100_00101_010, ROM[2]=18'b00001_00010_00110_101, ROM[3]=0; pulse start -> expected response:
  - three we pulses, 3 cycles apart, with (Dir1,Dir2,DirEs,Selec) = (1,2,3,0000), (3,4,5,0010), (1,2,6,0101);
  - then done pulses once and instr_count=3.
- ROM[0]=0 (immediate HALT), start -> expected response:
  - no we pulse;
  - done pulses 2 cycles after FETCH;
  - instr_count=0, busy high for FETCH and DECODE only.
- ROM[0]=18'b00001_00010_00000_000, ROM[1]=0 -> expected response:
  - EXEC occurs with DirEs=0 and we stays 0;
  - instr_count=1.
- ROM filled with nonzero words (no HALT), PC_W=3 -> expected response:
  - 8 instructions execute and pc_out reaches 7;
  - then DONE with instr_count=8, and no fetch at address 0 after the wrap point.
- Assert rst during the EXEC cycle of ROM[1] -> expected response:
  - we, busy and outputs go to 0 before the next clock edge;
  - state returns to IDLE; a subsequent start re-executes from PC=0.
- Pulse start again mid-run (during DECODE of ROM[1]) -> expected response: ignored; instruction sequence and instr_count are identical to the first scenario.
